// File: rtl/centroid_tracker_mc.sv
// Multi-channel centroid tracker: per-channel x/y sums and counts, snapshotted on
// tabulate_in, then serialised through one shared restoring divider.
//   state  | meaning
//   IDLE   | waiting for tabulate_in
//   LOAD   | select channel ch; zero-count channels skip the divider
//   DIV_X  | SX_W restoring steps of sum_x / cnt
//   DIV_Y  | SX_W restoring steps of sum_y / cnt (dividend zero-extended)
//   EMIT   | present channel ch result for one cycle
module centroid_tracker_mc #(
  parameter int N_CH      = 4,
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int CNT_W     = 20,
  parameter int MIN_COUNT = 16
) (
  input  logic                                     clk_in,
  input  logic                                     rst_n_in,
  input  logic [X_W-1:0]                           x_in,
  input  logic [Y_W-1:0]                           y_in,
  input  logic                                     valid_in,
  input  logic [N_CH-1:0]                          ch_mask_in,
  input  logic                                     tabulate_in,
  output logic [X_W-1:0]                           x_out,
  output logic [Y_W-1:0]                           y_out,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_out,
  output logic [CNT_W-1:0]                         count_out,
  output logic                                     found_out,
  output logic                                     sat_out,
  output logic                                     valid_out,
  output logic                                     frame_done_out,
  output logic                                     busy_out,
  output logic                                     overrun_out
);
  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BC_W = $clog2(SX_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DIV_X = 3'd2;
  localparam logic [2:0] S_DIV_Y = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

  logic [SX_W-1:0]  sum_x_q [N_CH], sum_x_d [N_CH], sh_sx_q [N_CH], sh_sx_d [N_CH];
  logic [SY_W-1:0]  sum_y_q [N_CH], sum_y_d [N_CH], sh_sy_q [N_CH], sh_sy_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH], cnt_d [N_CH], sh_cnt_q [N_CH], sh_cnt_d [N_CH];

  logic [2:0]       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [SX_W-1:0]  quot_q, quot_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [X_W-1:0]   qx_q, qx_d;

  logic [X_W-1:0]   x_out_q, x_out_d;
  logic [Y_W-1:0]   y_out_q, y_out_d;
  logic [CH_W-1:0]  ch_out_q, ch_out_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             found_q, found_d, sat_q, sat_d, overrun_q, overrun_d;

  logic             tab_acc;
  logic [CNT_W-1:0] cnt_sel, rem_nxt;
  logic [CNT_W:0]   trial;
  logic             q_bit;
  logic [SX_W-1:0]  quot_nxt;

  assign tab_acc = tabulate_in && (state_q == S_IDLE);

  // A pixel on the accepted tabulate edge seeds the new frame instead of zero.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      sum_x_d[k]  = sum_x_q[k];
      sum_y_d[k]  = sum_y_q[k];
      cnt_d[k]    = cnt_q[k];
      sh_sx_d[k]  = sh_sx_q[k];
      sh_sy_d[k]  = sh_sy_q[k];
      sh_cnt_d[k] = sh_cnt_q[k];
      if (tab_acc) begin
        sh_sx_d[k]  = sum_x_q[k];
        sh_sy_d[k]  = sum_y_q[k];
        sh_cnt_d[k] = cnt_q[k];
        sum_x_d[k]  = (valid_in && ch_mask_in[k]) ? SX_W'(x_in) : '0;
        sum_y_d[k]  = (valid_in && ch_mask_in[k]) ? SY_W'(y_in) : '0;
        cnt_d[k]    = (valid_in && ch_mask_in[k]) ? CNT_W'(1) : '0;
      end else if (valid_in && ch_mask_in[k] && (cnt_q[k] != CNT_MAX)) begin
        sum_x_d[k] = sum_x_q[k] + SX_W'(x_in);
        sum_y_d[k] = sum_y_q[k] + SY_W'(y_in);
        cnt_d[k]   = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Shadows are stable while busy, so the divisor is read straight from them.
  always_comb begin
    cnt_sel  = sh_cnt_q[ch_q];
    trial    = {rem_q, quot_q[SX_W-1]};
    q_bit    = (trial >= {1'b0, cnt_sel});
    rem_nxt  = q_bit ? CNT_W'(trial - {1'b0, cnt_sel}) : trial[CNT_W-1:0];
    quot_nxt = {quot_q[SX_W-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bc_d        = bc_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    qx_d        = qx_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    ch_out_d    = ch_out_q;
    count_out_d = count_out_q;
    found_d     = found_q;
    sat_d       = sat_q;
    overrun_d   = tabulate_in && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (tabulate_in) begin
          state_d = S_LOAD;
          ch_d    = '0;
        end
      end
      S_LOAD: begin
        if (cnt_sel == '0) begin
          state_d     = S_EMIT;
          x_out_d     = '0;
          y_out_d     = '0;
          ch_out_d    = ch_q;
          count_out_d = '0;
          found_d     = 1'b0;
          sat_d       = 1'b0;
        end else begin
          state_d = S_DIV_X;
          quot_d  = sh_sx_q[ch_q];
          rem_d   = '0;
          bc_d    = BC_W'(SX_W - 1);
        end
      end
      S_DIV_X: begin
        quot_d = quot_nxt;
        rem_d  = rem_nxt;
        bc_d   = bc_q - BC_W'(1);
        if (bc_q == '0) begin
          state_d = S_DIV_Y;
          qx_d    = quot_nxt[X_W-1:0];
          quot_d  = SX_W'(sh_sy_q[ch_q]);
          rem_d   = '0;
          bc_d    = BC_W'(SX_W - 1);
        end
      end
      S_DIV_Y: begin
        quot_d = quot_nxt;
        rem_d  = rem_nxt;
        bc_d   = bc_q - BC_W'(1);
        if (bc_q == '0) begin
          state_d     = S_EMIT;
          x_out_d     = qx_q;
          y_out_d     = quot_nxt[Y_W-1:0];
          ch_out_d    = ch_q;
          count_out_d = cnt_sel;
          found_d     = (64'(cnt_sel) >= 64'(MIN_COUNT)) && (cnt_sel != '0);
          sat_d       = (cnt_sel == CNT_MAX);
        end
      end
      S_EMIT: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < N_CH; k++) begin
        sum_x_q[k]  <= '0;
        sum_y_q[k]  <= '0;
        cnt_q[k]    <= '0;
        sh_sx_q[k]  <= '0;
        sh_sy_q[k]  <= '0;
        sh_cnt_q[k] <= '0;
      end
      state_q     <= S_IDLE;
      ch_q        <= '0;
      bc_q        <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      qx_q        <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      ch_out_q    <= '0;
      count_out_q <= '0;
      found_q     <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        sum_x_q[k]  <= sum_x_d[k];
        sum_y_q[k]  <= sum_y_d[k];
        cnt_q[k]    <= cnt_d[k];
        sh_sx_q[k]  <= sh_sx_d[k];
        sh_sy_q[k]  <= sh_sy_d[k];
        sh_cnt_q[k] <= sh_cnt_d[k];
      end
      state_q     <= state_d;
      ch_q        <= ch_d;
      bc_q        <= bc_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      qx_q        <= qx_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      ch_out_q    <= ch_out_d;
      count_out_q <= count_out_d;
      found_q     <= found_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign x_out          = x_out_q;
  assign y_out          = y_out_q;
  assign ch_out         = ch_out_q;
  assign count_out      = count_out_q;
  assign found_out      = found_q;
  assign sat_out        = sat_q;
  assign overrun_out    = overrun_q;
  assign valid_out      = (state_q == S_EMIT);
  assign frame_done_out = (state_q == S_EMIT) && (ch_q == CH_W'(N_CH - 1));
  assign busy_out       = (state_q != S_IDLE);

endmodule

// File: doc/centroid_tracker_mc.md
Name: centroid_tracker_mc

Overview:
Multi-channel, parametrised successor to the single-object centre-of-mass unit. Accumulates x/y pixel sums and counts for N_CH independent masks (e.g. colour thresholds) during a frame. On tabulate_in it snapshots all accumulators into shadow registers, so the next frame's accumulation starts with no dead cycle. One shared restoring divider then serialises the per-channel centroids onto a single result stream, between the pixel-mask stage and the overlay/tracking logic.

Parameters:
N_CH, 4, number of channels (1..16)
X_W, 11, pixel x coordinate width
Y_W, 10, pixel y coordinate width
CNT_W, 20, per-channel pixel counter width
MIN_COUNT, 16, minimum pixel count for found_out=1

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
x_in  input  X_W  pixel x
y_in  input  Y_W  pixel y
valid_in  input  1  pixel qualifier
ch_mask_in  input  N_CH  bit k=1: pixel belongs to channel k (multiple bits allowed)
tabulate_in  input  1  end-of-frame pulse
x_out  output  X_W  centroid x of channel ch_out
y_out  output  Y_W  centroid y of channel ch_out
ch_out  output  max(1,$clog2(N_CH))  channel index of current result
count_out  output  CNT_W  pixel count of channel ch_out
found_out  output  1  count_out >= MIN_COUNT and count_out != 0
sat_out  output  1  channel counter saturated this frame
valid_out  output  1  one-cycle result strobe
frame_done_out  output  1  high with valid_out of channel N_CH-1
busy_out  output  1  divider engine not IDLE
overrun_out  output  1  one-cycle pulse: tabulate_in dropped

Behaviour:
- Reset is asynchronous. All accumulators, shadows, FSM and outputs clear to 0, FSM goes to IDLE.
- Reset mid-division aborts the division. No valid_out is produced afterwards for the aborted frame.
- Accumulate: on valid_in, for each k with ch_mask_in[k]=1: sum_x[k]+=x_in, sum_y[k]+=y_in, cnt[k]+=1.
- Sum widths: SX_W=X_W+CNT_W, SY_W=Y_W+CNT_W, so sums cannot overflow while cnt is unsaturated.
- Saturation: when cnt[k] reaches 2^CNT_W-1, channel k freezes (further pixels ignored) and sat[k] is set for the frame.
- Tabulate accepted (FSM IDLE):
  - Same edge: shadows <= accumulators and accumulators <= 0.
  - A pixel on the tabulate cycle is counted in the NEW frame (accumulator loads that pixel rather than 0).
- Tabulate while busy_out=1: ignored. Accumulators keep summing into the current frame, overrun_out pulses one cycle, and the in-flight results stream unchanged.
- FSM: IDLE -> LOAD(ch=0) on accepted tabulate.
  - LOAD: if shadow cnt=0 -> EMIT, with x_out=y_out=0, found_out=0. Otherwise -> DIV_X.
  - DIV_X: D=SX_W cycles, 1 quotient bit per cycle, then -> DIV_Y.
  - DIV_Y: D cycles, dividend zero-extended to SX_W, then -> EMIT.
  - EMIT: drives all result outputs and valid_out for exactly 1 cycle. ch<N_CH-1 -> LOAD(ch+1); else frame_done_out=1 -> IDLE.
- Quotient is floor(sum/cnt), truncated to X_W / Y_W. It fits in those widths because the mean cannot exceed the max coordinate.
- Latency with tabulate at cycle T (accepted at edge T):
  - LOAD at T+1; EMIT for a nonzero channel at T+2+2D (defaults: D=31, EMIT at T+64).
  - Each nonzero channel occupies 2D+2 cycles; a zero-count channel occupies 2 cycles.
- Result outputs hold their last values between strobes. valid_out, frame_done_out and overrun_out are pulses.
- busy_out = (FSM != IDLE), combinational from the state register.

Test Plan:
- Reset then 4 pixels on ch0 at (10,20),(12,22),(14,24),(16,26); tabulate -> valid_out at T+64: ch_out=0, x_out=13, y_out=23, count_out=4, found_out=0 (MIN_COUNT=16). Then ch1..3 emit 0/found_out=0 at 2-cycle spacing; frame_done_out with ch_out=3.
- 100 pixels ch_mask=4'b0011 at (1023,767) -> ch0 and ch1 both x_out=1023, y_out=767, count_out=100, found_out=1.
- Floor check: ch2 pixels x=1,2 (sum 3, cnt 2) -> x_out=1.
- Pixel (5,5) on ch0 coincident with tabulate -> it is excluded from the emitted frame. The next frame with no further pixels reports x_out=5, count_out=1.
- Second tabulate 10 cycles after the first -> overrun_out pulses once; the first frame's four results are unaffected; pixels after it still accumulate and emit on the next accepted tabulate.
- CNT_W=4: feed 20 ch0 pixels at x=8 -> count_out=15, sat_out=1, x_out=8. Separately, rst_n_in low at T+30 mid-division -> outputs 0 immediately, no valid_out, busy_out=0.
